cp0_unit: RTL and testbench

- Coprocessor-0 for the P7 pipeline. Sits directly downstream of the M-stage exception detector and consumes its ExcCode together with the macro PC of the M-stage instruction.
- Holds SR (12), Cause (13), EPC (14) and PRId (15).
- Arbitrates hardware interrupts against synchronous exceptions and raises Req to flush the pipeline and redirect NPC to the handler.
- Serves mfc0, mtc0 and eret.

---
 rtl/cp0_defs.sv | 36 +++
 rtl/cp0_unit.sv | 113 +++++++++++
 tb/tb_cp0_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_defs.sv
// rtl/cp0_defs.sv - shared CP0 register indices, exception codes and field layout
//   Package only, no ports. Imported by cp0_unit.

package cp0_defs;

    // Register indices as seen by mfc0/mtc0
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Architectural exception codes (Cause.ExcCode)
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // SR field positions
    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_LO  = 10;
    localparam int SR_IM_HI  = 15;

    // Cause field positions
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    // Bits of SR that hold state; everything else reads 0
    localparam logic [31:0] SR_WRITE_MASK = 32'h0000_FC03;

endpackage

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - coprocessor 0: SR/Cause/EPC/PRId, interrupt/exception request
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   En         in   mtc0 write enable (M stage)
//   CP0Add     in   [4:0]  register index for mtc0/mfc0
//   CP0In      in   [31:0] mtc0 write data
//   VPC        in   [31:0] PC of the M-stage instruction
//   BDIn       in   M-stage instruction sits in a branch delay slot
//   ExcCodeIn  in   [5:0]  exception code from M-stage detector, 0 = none
//   HWInt      in   [5:0]  external interrupt lines
//   EXLClr     in   eret executing in M
//   CP0Out     out  [31:0] mfc0 read data
//   EPCOut     out  [31:0] current EPC (eret target)
//   HandlerPC  out  [31:0] exception entry address
//   Req        out  take exception/interrupt this cycle

module cp0_unit
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID    = 32'h2024_1127,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        En,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [5:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] CP0Out,
    output logic [31:0] EPCOut,
    output logic [31:0] HandlerPC,
    output logic        Req
);

    // Only the defined fields are stored; the full words are assembled below.
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  excCode;
    logic [31:0] epc;

    logic        intReq;
    logic        excReq;
    logic [31:0] srValue;
    logic [31:0] causeValue;

    assign srValue    = {16'b0, im, 8'b0, exl, ie};
    assign causeValue = {bd, 15'b0, ip, 3'b0, excCode, 2'b0};

    // Interrupts are sampled from the live lines, not Cause.IP, so a request
    // is seen in the same cycle the line rises.
    assign intReq = (|(HWInt & im)) & ie & ~exl;
    assign excReq = (ExcCodeIn != 6'd0) & ~exl;
    assign Req    = intReq | excReq;

    assign EPCOut    = epc;
    assign HandlerPC = HANDLER;

    always_comb begin
        CP0Out = 32'd0;
        case (CP0Add)
            REG_SR:    CP0Out = srValue;
            REG_CAUSE: CP0Out = causeValue;
            REG_EPC:   CP0Out = epc;
            REG_PRID:  CP0Out = PRID;
            default:   CP0Out = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im      <= '0;
            exl     <= 1'b0;
            ie      <= 1'b0;
            bd      <= 1'b0;
            ip      <= '0;
            excCode <= '0;
            epc     <= '0;
        end else begin
            ip <= HWInt;
            if (Req) begin
                // The M-stage instruction is cancelled, so any mtc0/eret it
                // carries is dropped along with it.
                exl     <= 1'b1;
                bd      <= BDIn;
                excCode <= intReq ? EXC_INT : ExcCodeIn[4:0];
                epc     <= BDIn ? (VPC - 32'd4) : VPC;
            end else begin
                if (EXLClr) begin
                    exl <= 1'b0;
                end
                if (En) begin
                    case (CP0Add)
                        REG_SR: begin
                            im  <= CP0In[SR_IM_HI:SR_IM_LO];
                            exl <= CP0In[SR_EXL];
                            ie  <= CP0In[SR_IE];
                        end
                        REG_EPC: epc <= CP0In;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - self-checking bench for cp0_unit

module tb_cp0_unit;

    localparam logic [31:0] PRID    = 32'h2024_1127;
    localparam logic [31:0] HANDLER = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        En;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] VPC;
    logic        BDIn;
    logic [5:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] CP0Out;
    logic [31:0] EPCOut;
    logic [31:0] HandlerPC;
    logic        Req;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference state as whole architectural words
    logic [31:0] mSr, mCause, mEpc;

    cp0_unit #(.PRID(PRID), .HANDLER(HANDLER)) dut (
        .clk(clk), .reset(reset), .En(En), .CP0Add(CP0Add), .CP0In(CP0In),
        .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .CP0Out(CP0Out), .EPCOut(EPCOut),
        .HandlerPC(HandlerPC), .Req(Req)
    );

    always #5 clk = ~clk;

    function automatic logic mIntReq();
        return ((HWInt & mSr[15:10]) != 6'd0) && mSr[0] && !mSr[1];
    endfunction

    function automatic logic mReq();
        return mIntReq() || ((ExcCodeIn != 6'd0) && !mSr[1]);
    endfunction

    function automatic logic [31:0] mRead(input logic [4:0] a);
        if (a == 5'd12) return mSr;
        if (a == 5'd13) return mCause;
        if (a == 5'd14) return mEpc;
        if (a == 5'd15) return PRID;
        return 32'd0;
    endfunction

    task automatic mReset();
        mSr = 32'd0; mCause = 32'd0; mEpc = 32'd0;
    endtask

    // Advance one clock edge and apply the architectural rules to the model.
    task automatic tick();
        logic [31:0] nSr, nCause, nEpc;
        nSr    = mSr;
        nEpc   = mEpc;
        nCause = (mCause & ~32'h0000_FC00) | (32'(HWInt) << 10);
        if (mReq()) begin
            nSr    = mSr | 32'h2;
            nCause = (nCause & 32'h0000_FC00) | (32'(BDIn) << 31)
                   | ((mIntReq() ? 32'd0 : 32'(ExcCodeIn[4:0])) << 2);
            nEpc   = BDIn ? VPC - 32'd4 : VPC;
        end else begin
            if (EXLClr) nSr = nSr & ~32'h2;
            if (En && CP0Add == 5'd12) nSr = CP0In & 32'h0000_FC03;
            if (En && CP0Add == 5'd14) nEpc = CP0In;
        end
        @(posedge clk);
        #1;
        mSr = nSr; mCause = nCause; mEpc = nEpc;
    endtask

    task automatic readReg(input logic [4:0] a, output logic [31:0] d);
        CP0Add = a;
        #1;
        d = CP0Out;
    endtask

    task automatic idleInputs();
        En = 0; CP0Add = 5'd0; CP0In = 0; VPC = 32'h0000_3000; BDIn = 0;
        ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        En = 1; CP0Add = a; CP0In = d;
        tick();
        En = 0;
    endtask

    task automatic eret();
        EXLClr = 1;
        tick();
        EXLClr = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1;
        idleInputs();
        mReset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        #1;
        nCompared++;
        if (Req !== 1'b0) begin nMismatched++; $display("FAIL reset_req got %b want 0", Req); end
        nCompared++;
        if (EPCOut !== 32'd0) begin nMismatched++; $display("FAIL reset_epcout got %h want 0", EPCOut); end
        for (int a = 12; a <= 14; a++) begin
            readReg(5'(a), d);
            nCompared++;
            if (d !== 32'd0) begin nMismatched++; $display("FAIL reset_reg%0d got %h want 0", a, d); end
        end
        CP0Add = 0;
    endtask

    task automatic test_exception();
        logic [31:0] d;
        ExcCodeIn = 6'd5; VPC = 32'h0000_3010; BDIn = 0;
        #1;
        nCompared++;
        if (Req !== 1'b1) begin nMismatched++; $display("FAIL exc_req got %b want 1", Req); end
        tick();
        nCompared++;
        if (EPCOut !== 32'h0000_3010) begin nMismatched++; $display("FAIL exc_epc got %h want 00003010", EPCOut); end
        readReg(5'd13, d);
        nCompared++;
        if (d !== 32'h0000_0014) begin nMismatched++; $display("FAIL exc_cause got %h want 00000014", d); end
        readReg(5'd12, d);
        nCompared++;
        if (d[1] !== 1'b1) begin nMismatched++; $display("FAIL exc_exl got %b want 1", d[1]); end
        nCompared++;
        if (Req !== 1'b0) begin nMismatched++; $display("FAIL exc_masked_req got %b want 0", Req); end
        ExcCodeIn = 0;
        eret();
    endtask

    task automatic test_delay_slot();
        logic [31:0] d;
        ExcCodeIn = 6'd12; VPC = 32'h0000_3024; BDIn = 1;
        tick();
        ExcCodeIn = 0; BDIn = 0;
        nCompared++;
        if (EPCOut !== 32'h0000_3020) begin nMismatched++; $display("FAIL bd_epc got %h want 00003020", EPCOut); end
        readReg(5'd13, d);
        nCompared++;
        if (d[31] !== 1'b1 || d[6:2] !== 5'd12) begin
            nMismatched++; $display("FAIL bd_cause got bd=%b code=%0d want bd=1 code=12", d[31], d[6:2]);
        end
        eret();
    endtask

    task automatic test_interrupt();
        logic [31:0] d;
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001;
        #1;
        nCompared++;
        if (Req !== 1'b1) begin nMismatched++; $display("FAIL int_req got %b want 1", Req); end
        tick();
        readReg(5'd13, d);
        nCompared++;
        if (d[6:2] !== 5'd0 || d[10] !== 1'b1) begin
            nMismatched++; $display("FAIL int_cause got %h want code=0 ip0=1", d);
        end
        HWInt = 0;
        eret();
        mtc0(5'd12, 32'h0000_0400);
        HWInt = 6'b000001;
        #1;
        nCompared++;
        if (Req !== 1'b0) begin nMismatched++; $display("FAIL int_ie0_req got %b want 0", Req); end
        tick();
        HWInt = 6'b100110;
        tick();
        readReg(5'd13, d);
        nCompared++;
        if (d[15:10] !== 6'b100110) begin nMismatched++; $display("FAIL int_ip_track got %b want 100110", d[15:10]); end
        HWInt = 0;
    endtask

    task automatic test_priority();
        logic [31:0] d;
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001; ExcCodeIn = 6'd4; VPC = 32'h0000_3100; BDIn = 0;
        En = 1; CP0Add = 5'd14; CP0In = 32'hDEAD_BEEF;
        #1;
        nCompared++;
        if (Req !== 1'b1) begin nMismatched++; $display("FAIL prio_req got %b want 1", Req); end
        tick();
        En = 0; ExcCodeIn = 0;
        nCompared++;
        if (EPCOut !== 32'h0000_3100) begin nMismatched++; $display("FAIL prio_epc got %h want 00003100", EPCOut); end
        readReg(5'd13, d);
        nCompared++;
        if (d[6:2] !== 5'd0) begin nMismatched++; $display("FAIL prio_code got %0d want 0", d[6:2]); end
    endtask

    task automatic test_eret();
        logic [31:0] d;
        // EXL=1 from the previous interrupt, HWInt[0] still pending
        nCompared++;
        if (Req !== 1'b0) begin nMismatched++; $display("FAIL eret_pre_req got %b want 0", Req); end
        eret();
        readReg(5'd12, d);
        nCompared++;
        if (d !== 32'h0000_0401) begin nMismatched++; $display("FAIL eret_sr got %h want 00000401", d); end
        nCompared++;
        if (EPCOut !== 32'h0000_3100) begin nMismatched++; $display("FAIL eret_epc got %h want 00003100", EPCOut); end
        nCompared++;
        if (Req !== 1'b1) begin nMismatched++; $display("FAIL eret_pending_req got %b want 1", Req); end
        HWInt = 0;
        #1;
    endtask

    task automatic test_reads();
        logic [31:0] d;
        readReg(5'd15, d);
        nCompared++;
        if (d !== PRID) begin nMismatched++; $display("FAIL read_prid got %h want %h", d, PRID); end
        readReg(5'd7, d);
        nCompared++;
        if (d !== 32'd0) begin nMismatched++; $display("FAIL read_unmapped got %h want 0", d); end
        nCompared++;
        if (HandlerPC !== HANDLER) begin nMismatched++; $display("FAIL handler_pc got %h want %h", HandlerPC, HANDLER); end
        mtc0(5'd12, 32'hFFFF_FFFF);
        readReg(5'd12, d);
        nCompared++;
        if (d !== 32'h0000_FC03) begin nMismatched++; $display("FAIL sr_mask got %h want 0000FC03", d); end
        mtc0(5'd14, 32'h1234_5678);
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        HWInt = 6'b010000;
        tick();
        #2;
        reset = 1;
        mReset();
        #1;
        for (int a = 12; a <= 14; a++) begin
            readReg(5'(a), d);
            nCompared++;
            if (d !== 32'd0) begin nMismatched++; $display("FAIL async_reset_reg%0d got %h want 0", a, d); end
        end
        nCompared++;
        if (EPCOut !== 32'd0) begin nMismatched++; $display("FAIL async_reset_epcout got %h want 0", EPCOut); end
        #1;
        reset = 0;
        HWInt = 0;
        tick();
    endtask

    task automatic test_random();
        logic [4:0] codes [6];
        codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
        for (int i = 0; i < 400; i++) begin
            HWInt     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            ExcCodeIn = ($urandom_range(0, 4) == 0) ? {1'b0, codes[$urandom_range(0, 5)]} : 6'd0;
            En        = ($urandom_range(0, 3) == 0);
            CP0Add    = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            CP0In     = $urandom;
            VPC       = {16'd0, 14'($urandom), 2'b00};
            BDIn      = 1'($urandom);
            EXLClr    = ($urandom_range(0, 3) == 0);
            #1;
            nCompared++;
            if (Req !== mReq()) begin nMismatched++; $display("FAIL rand_req[%0d] got %b want %b", i, Req, mReq()); end
            nCompared++;
            if (CP0Out !== mRead(CP0Add)) begin
                nMismatched++; $display("FAIL rand_read[%0d] idx=%0d got %h want %h", i, CP0Add, CP0Out, mRead(CP0Add));
            end
            nCompared++;
            if (EPCOut !== mEpc) begin nMismatched++; $display("FAIL rand_epc[%0d] got %h want %h", i, EPCOut, mEpc); end
            tick();
        end
        idleInputs();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_delay_slot();
        test_interrupt();
        test_priority();
        test_eret();
        test_reads();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
